// File: rtl/alu6_mul_seq.sv
// Unsigned shift-add multiplier sequencer that borrows an external ALU6 as its adder.
// One partial-product bit per cycle; the ALU carry-out becomes the top sum bit.
module alu6_mul_seq #(
  parameter int unsigned WIDTH  = 6,
  parameter logic [3:0]  ADD_OP = 4'b0010
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_mcand,
  input  logic [WIDTH-1:0]     req_mplier,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2*WIDTH-1:0]   resp_product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_carryin,
  output logic [3:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  assign req_ready    = (r_state == IDLE) & ~reset;
  assign resp_valid   = (r_state == DONE);
  assign resp_product = {r_acc, r_q};
  assign alu_carryin  = 1'b0;
  assign alu_op       = ADD_OP;
  assign w_accept     = req_valid & req_ready;

  // Next-state decode and ALU operand drive
  always_comb begin
    w_next = r_state;
    alu_a  = '0;
    alu_b  = '0;
    unique case (r_state)
      IDLE: if (w_accept) w_next = CALC;
      CALC: begin
        alu_a = r_acc;
        alu_b = r_q[0] ? r_m : '0;
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, operand and partial-product registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_m   <= req_mcand;
        r_q   <= req_mplier;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        // carry-out is the (WIDTH+1)th sum bit; the sum's LSB shifts into q
        {r_acc, r_q} <= {alu_carryout, alu_result, r_q[WIDTH-1:1]};
        r_cnt        <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu6_mul_seq.sv
// Self-checking bench for alu6_mul_seq with a behavioural ALU6 stand-in.
module tb_alu6_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_mcand;
  logic [5:0]  req_mplier;
  logic        resp_valid;
  logic        resp_ready;
  logic [11:0] resp_product;
  logic [5:0]  alu_a;
  logic [5:0]  alu_b;
  logic        alu_carryin;
  logic [3:0]  alu_op;
  logic [5:0]  alu_result;
  logic        alu_carryout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU6 stand-in: ADD only, anything else yields zero
  always_comb begin
    {alu_carryout, alu_result} = 7'd0;
    if (alu_op == 4'b0010)
      {alu_carryout, alu_result} = 7'({1'b0, alu_a} + {1'b0, alu_b} + {6'd0, alu_carryin});
  end

  alu6_mul_seq #(.WIDTH(6), .ADD_OP(4'b0010)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mcand    (req_mcand),
    .req_mplier   (req_mplier),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_carryin  (alu_carryin),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full multiply: accept, walk CALC checking ALU drive, optionally stall DONE
  task automatic do_mul(input int unsigned m, input int unsigned q, input int unsigned hold);
    int unsigned n;
    int unsigned prod;
    int unsigned part;
    prod = m * q;
    resp_ready = (hold == 0);
    check("idle_ready", req_ready, 1);
    req_valid  = 1'b1;
    req_mcand  = 6'(m);
    req_mplier = 6'(q);
    step();
    req_valid  = 1'b0;
    req_mcand  = 6'($urandom);
    req_mplier = 6'($urandom);
    n = 0;
    while (!resp_valid && n < 20) begin
      if (n < 6) begin
        part = (m * (q & ((1 << n) - 1))) >> n;
        check("calc_alu_a", alu_a, part);
        check("calc_alu_b", alu_b, ((q >> n) & 1) != 0 ? m : 0);
        check("calc_ready", req_ready, 0);
      end
      step();
      n++;
    end
    check("latency", n, 6);
    check("product", resp_product, prod);
    check("done_alu_a", alu_a, 0);
    for (int unsigned i = 0; i < hold; i++) begin
      req_valid  = (i == 1);
      req_mcand  = 6'($urandom);
      req_mplier = 6'($urandom);
      step();
      req_valid = 1'b0;
      check("stall_valid", resp_valid, 1);
      check("stall_ready", req_ready, 0);
      check("stall_product", resp_product, prod);
    end
    resp_ready = 1'b1;
    step();
    check("post_valid", resp_valid, 0);
    check("post_ready", req_ready, 1);
    check("post_held", resp_product, prod);
  endtask

  initial begin
    int unsigned acc_cyc[$];
    int unsigned rsp_cyc[$];
    int unsigned rsp_val[$];
    int unsigned n_acc;
    logic        prev_valid;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_mcand  = '0;
    req_mplier = '0;
    resp_ready = 1'b0;
    step();
    check("rst_ready", req_ready, 0);
    step();
    reset = 1'b0;
    #1;
    check("rst_rdy_after", req_ready, 1);
    check("rst_valid", resp_valid, 0);
    check("rst_product", resp_product, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("alu_op", alu_op, 4'b0010);
    check("alu_cin", alu_carryin, 0);

    do_mul(7, 6, 0);
    do_mul(63, 63, 0);
    do_mul(0, 45, 0);
    do_mul(45, 0, 0);
    do_mul(5, 9, 5);

    // reset mid-calculation
    req_valid  = 1'b1;
    req_mcand  = 6'd63;
    req_mplier = 6'd1;
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("midrst_ready", req_ready, 0);
    check("midrst_valid", resp_valid, 0);
    check("midrst_product", resp_product, 0);
    reset = 1'b0;
    #1;
    check("midrst_rdy_after", req_ready, 1);
    for (int unsigned i = 0; i < 8; i++) begin
      step();
      check("midrst_no_resp", resp_valid, 0);
    end
    do_mul(2, 3, 0);

    // back-to-back with req_valid held
    n_acc      = 0;
    prev_valid = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_mcand  = 6'd1;
    req_mplier = 6'd1;
    for (int unsigned i = 0; i < 40 && rsp_val.size() < 2; i++) begin
      if (req_valid && req_ready) begin
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      step();
      if (n_acc == 1) begin
        req_mcand  = 6'd63;
        req_mplier = 6'd2;
      end else if (n_acc >= 2) begin
        req_valid = 1'b0;
      end
      if (resp_valid && !prev_valid) begin
        rsp_cyc.push_back(cyc);
        rsp_val.push_back(32'(resp_product));
      end
      prev_valid = resp_valid;
    end
    check("b2b_accepts", acc_cyc.size(), 2);
    check("b2b_resps", rsp_val.size(), 2);
    if (acc_cyc.size() == 2)
      check("b2b_interval", acc_cyc[1] - acc_cyc[0], 8);
    if (rsp_val.size() == 2) begin
      check("b2b_prod0", rsp_val[0], 32'h001);
      check("b2b_prod1", rsp_val[1], 32'h07E);
      check("b2b_resp_gap", rsp_cyc[1] - rsp_cyc[0], 8);
    end
    req_valid = 1'b0;
    for (int unsigned i = 0; i < 10 && !req_ready; i++) step();

    // randomized operands and stall lengths
    for (int unsigned t = 0; t < 30; t++)
      do_mul($urandom_range(63, 0), $urandom_range(63, 0), $urandom_range(3, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
